// File: rtl/seg7_pkg.sv
// seg7_pkg: scan FSM states and active-high 7-segment patterns {g,f,e,d,c,b,a}
package seg7_pkg;
  typedef enum logic {S_LOW, S_HIGH} state_t;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-high 7-segment decode, dash for non-BCD
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_seg7_scan_2digit.sv
// bcd_seg7_scan_2digit: frame-coherent 2-digit 7-segment scanner with anti-ghost blank.
// Optional LZ_BLANK_EN blanks the high digit slot when the tens snapshot is 0.
module bcd_seg7_scan_2digit
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] high,
  input  logic [3:0] low,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] div_cnt;
  state_t state;
  logic [3:0] high_q, low_q;
  logic slot_end, blank;
  logic [3:0] digit;
  logic [6:0] dec, seg_n;
  logic [1:0] an_n;
  assign slot_end = div_cnt == CW'(REFRESH_DIV - 1);
  assign digit = (state == S_HIGH) ? high_q : low_q;
  bcd_to_seg7 u_dec (.bcd(digit), .seg(dec));
`ifdef LZ_BLANK_EN
  assign blank = (div_cnt == '0) || (state == S_HIGH && high_q == 4'd0);
`else
  assign blank = div_cnt == '0;
`endif
  assign seg_n = blank ? SEG_OFF : dec;
  assign an_n = blank ? 2'b00 : ((state == S_HIGH) ? 2'b10 : 2'b01);
  // Snapshot and err update only at the frame boundary (end of the high slot)
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt <= '0;
      state <= S_LOW;
      high_q <= 4'd0;
      low_q <= 4'd0;
      err <= 1'b0;
      seg <= {7{SEG_ACT_LOW}};
      an <= {2{SEG_ACT_LOW}};
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) state <= (state == S_LOW) ? S_HIGH : S_LOW;
      if (slot_end && state == S_HIGH) begin
        high_q <= high;
        low_q <= low;
        err <= (high > 4'd9) || (low > 4'd9);
      end
      seg <= seg_n ^ {7{SEG_ACT_LOW}};
      an <= an_n ^ {2{SEG_ACT_LOW}};
    end
  end
endmodule

// File: tb/tb_bcd_seg7_scan_2digit.sv
// tb_bcd_seg7_scan_2digit: randomized self-checking bench against a frame-level display model
module tb_bcd_seg7_scan_2digit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] high = 4'd0, low = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic err;
  int compared = 0, mismatched = 0;
  int c = 0;
  logic [3:0] hq = 4'd0, lq = 4'd0;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic exp_err;
  logic [6:0] tbl [10];

  bcd_seg7_scan_2digit #(.REFRESH_DIV(4), .SEG_ACT_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .high(high), .low(low),
    .seg(seg), .an(an), .err(err)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] enc(input logic [3:0] d);
    return (d > 4'd9) ? ~7'h40 : ~tbl[d];
  endfunction

  // Model: cycle c since reset; slot = (c/4)%2, position in slot = c%4; frame = 8 cycles
  task automatic cycle();
    int pos, slot;
    logic blank;
    if (!reset) begin
      exp_seg = 7'h7F;
      exp_an = 2'b11;
      c = 0;
      hq = 4'd0;
      lq = 4'd0;
    end else begin
      pos = c % 4;
      slot = (c / 4) % 2;
      blank = (pos == 0);
`ifdef LZ_BLANK_EN
      if (slot == 1 && hq == 4'd0) blank = 1'b1;
`endif
      exp_seg = blank ? 7'h7F : enc(slot == 1 ? hq : lq);
      exp_an = blank ? 2'b11 : (slot == 1 ? 2'b01 : 2'b10);
      if (c % 8 == 7) begin
        hq = high;
        lq = low;
      end
      c++;
    end
    exp_err = (hq > 4'd9) || (lq > 4'd9);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    high = 4'd5;
    low = 4'd9;
    reset = 1'b0;
    repeat (3) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {7'h7F, 2'b11, 1'b0}) begin
        mismatched++;
        $display("FAIL reset: seg=%h an=%b err=%b, required seg=7f an=11 err=0", seg, an, err);
      end
    end
    reset = 1'b1;
    repeat (8) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL first_frame c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  endtask

  task automatic test_display();
    high = 4'd5;
    low = 4'd9;
    repeat (16) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL display c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    compared++;
    if (hq != 4'd5 || lq != 4'd9 || exp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL display_model: snapshot %0d%0d, required 59", hq, lq);
    end
  endtask

  task automatic test_mid_frame();
    low = 4'd3;
    for (int i = 0; i < 32 && !(c % 8 == 2 && lq == 4'd3); i++) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL mid_frame_pre c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    low = 4'd4;
    repeat (16) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL mid_frame c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  endtask

  task automatic test_err();
    high = 4'hC;
    low = 4'd2;
    repeat (16) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL err_set c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_flag: err=%b, required 1", err);
    end
    high = 4'd1;
    repeat (16) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL err_clear c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_cleared: err=%b, required 0", err);
    end
  endtask

  task automatic test_leading_zero();
    high = 4'd0;
    low = 4'd7;
    repeat (24) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL leading_zero c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  endtask

  task automatic test_mid_reset();
    high = 4'd3;
    low = 4'd8;
    for (int i = 0; i < 32 && !(c % 8 == 5 && hq == 4'd3); i++) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL mid_reset_pre c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    compared++;
    if ({seg, an, err} !== {7'h7F, 2'b11, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset: seg=%h an=%b err=%b, required seg=7f an=11 err=0", seg, an, err);
    end
    repeat (16) begin
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL mid_reset_post c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) begin
        high = 4'($urandom_range(0, 15));
        low = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 59) != 0);
      cycle();
      compared++;
      if ({seg, an, err} !== {exp_seg, exp_an, exp_err}) begin
        mismatched++;
        $display("FAIL random c=%0d h=%h l=%h: seg=%h an=%b err=%b, required seg=%h an=%b err=%b", c, high, low, seg, an, err, exp_seg, exp_an, exp_err);
      end
      compared++;
      if (an === 2'b00) begin
        mismatched++;
        $display("FAIL an_both: an=%b, required at most one active", an);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    test_reset();
    test_display();
    test_mid_frame();
    test_err();
    test_leading_zero();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
